// File: rtl/exec_writeback.sv
// exec_writeback
//   Execute-stage writeback for an ARM-style data-processing pipeline.
//   Evaluates the instruction condition against the committed flags,
//   updates NZCV, and queues register writebacks in a small FIFO that
//   the register file drains with a valid/ready handshake.
//
// Ports
//   in_Clock, in_Reset       clock, asynchronous active-high reset
//   in_Valid / out_Ready     ALU result handshake
//   in_Y, in_CNZV            ALU result and flags ({C,N,Z,V})
//   in_Opcode, in_SetFlags   data-processing opcode and S bit
//   in_Cond, in_Rd           condition field and destination register
//   in_Flush                 discard all queued writebacks
//   out_WbValid / in_WbReady writeback queue head handshake
//   out_WbRd, out_WbData     head destination and data
//   out_PcWrite              head targets r15
//   out_NZCV                 committed flags ({N,Z,C,V})

`ifndef WordWidth
`define WordWidth 32
`endif

module exec_writeback #(
    parameter int WordWidth = `WordWidth,
    parameter int Depth     = 2
) (
    input  logic                 in_Clock,
    input  logic                 in_Reset,
    input  logic                 in_Valid,
    output logic                 out_Ready,
    input  logic [WordWidth-1:0] in_Y,
    input  logic [3:0]           in_CNZV,
    input  logic [3:0]           in_Opcode,
    input  logic                 in_SetFlags,
    input  logic [3:0]           in_Cond,
    input  logic [3:0]           in_Rd,
    input  logic                 in_Flush,
    output logic                 out_WbValid,
    input  logic                 in_WbReady,
    output logic [3:0]           out_WbRd,
    output logic [WordWidth-1:0] out_WbData,
    output logic                 out_PcWrite,
    output logic [3:0]           out_NZCV
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [3:0]           nzcv_q, nzcv_d;
    logic                 live_q;

    logic [3:0]           rd_mem_q   [Depth];
    logic [WordWidth-1:0] data_mem_q [Depth];
    logic                 pc_mem_q   [Depth];

    logic accept, pass, is_test, is_arith, flag_upd, enq, deq, wb_valid;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // live_q keeps out_Ready low until the first edge after reset releases.
    assign wb_valid    = (count_q != '0);
    assign out_Ready   = live_q && (count_q < CntW'(Depth));
    assign out_WbValid = wb_valid;
    assign out_NZCV    = nzcv_q;

    // Storage is not reset; head fields are forced to zero while empty.
    assign out_WbRd    = wb_valid ? rd_mem_q[rd_ptr_q]   : '0;
    assign out_WbData  = wb_valid ? data_mem_q[rd_ptr_q] : '0;
    assign out_PcWrite = wb_valid ? pc_mem_q[rd_ptr_q]   : 1'b0;

    always_comb begin
        accept   = in_Valid && out_Ready;
        pass     = accept && cond_pass(in_Cond, nzcv_q);
        is_test  = (in_Opcode[3:2] == 2'b10);
        is_arith = ((in_Opcode >= 4'h2) && (in_Opcode <= 4'h7)) ||
                   (in_Opcode == 4'hA) || (in_Opcode == 4'hB);
        flag_upd = pass && (in_SetFlags || is_test);
        enq      = pass && !is_test && !in_Flush;
        deq      = wb_valid && in_WbReady && !in_Flush;

        // in_CNZV is {C,N,Z,V}; out_NZCV is {N,Z,C,V}. Logical ops keep V.
        nzcv_d = nzcv_q;
        if (flag_upd) begin
            nzcv_d = {in_CNZV[2], in_CNZV[1], in_CNZV[3],
                      is_arith ? in_CNZV[0] : nzcv_q[0]};
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge in_Clock or posedge in_Reset) begin
        if (in_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            nzcv_q   <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            nzcv_q   <= nzcv_d;
            live_q   <= 1'b1;
        end
    end

    always_ff @(posedge in_Clock) begin
        if (enq) begin
            rd_mem_q[wr_ptr_q]   <= in_Rd;
            data_mem_q[wr_ptr_q] <= in_Y;
            pc_mem_q[wr_ptr_q]   <= (in_Rd == 4'hF);
        end
    end

endmodule

// File: tb/tb_exec_writeback.sv
module tb_exec_writeback;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] y;
    logic [3:0]  cnzv;
    logic [3:0]  opcode;
    logic        setf;
    logic [3:0]  cond;
    logic [3:0]  rd;
    logic        flush;
    logic        wbready;

    logic        ready, wbvalid, pcwrite;
    logic [3:0]  wbrd, nzcv;
    logic [31:0] wbdata;

    logic        d4_ready, d4_wbvalid, d4_pcwrite;
    logic [3:0]  d4_wbrd, d4_nzcv;
    logic [31:0] d4_wbdata;

    int checks   = 0;
    int failures = 0;

    exec_writeback #(.WordWidth(32), .Depth(2)) u_dut (
        .in_Clock(clk), .in_Reset(rst), .in_Valid(valid), .out_Ready(ready),
        .in_Y(y), .in_CNZV(cnzv), .in_Opcode(opcode), .in_SetFlags(setf),
        .in_Cond(cond), .in_Rd(rd), .in_Flush(flush), .out_WbValid(wbvalid),
        .in_WbReady(wbready), .out_WbRd(wbrd), .out_WbData(wbdata),
        .out_PcWrite(pcwrite), .out_NZCV(nzcv)
    );

    // Deeper instance so a flush can coincide with an accept while entries are queued.
    exec_writeback #(.WordWidth(32), .Depth(4)) u_dut_d4 (
        .in_Clock(clk), .in_Reset(rst), .in_Valid(valid), .out_Ready(d4_ready),
        .in_Y(y), .in_CNZV(cnzv), .in_Opcode(opcode), .in_SetFlags(setf),
        .in_Cond(cond), .in_Rd(rd), .in_Flush(flush), .out_WbValid(d4_wbvalid),
        .in_WbReady(wbready), .out_WbRd(d4_wbrd), .out_WbData(d4_wbdata),
        .out_PcWrite(d4_pcwrite), .out_NZCV(d4_nzcv)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [3:0] op, input logic s, input logic [3:0] c,
                         input logic [3:0] r, input logic [31:0] val, input logic [3:0] f);
        valid  = 1'b1;
        opcode = op;
        setf   = s;
        cond   = c;
        rd     = r;
        y      = val;
        cnzv   = f;
    endtask

    task automatic idle();
        valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 0; rst = 1; valid = 0; y = '0; cnzv = '0; opcode = '0;
        setf = 0; cond = 4'hE; rd = '0; flush = 0; wbready = 0;

        // Reset state
        #2;
        check_eq("rst_ready",   ready,   0);
        check_eq("rst_wbvalid", wbvalid, 0);
        check_eq("rst_nzcv",    nzcv,    0);
        check_eq("rst_wbdata",  wbdata,  0);
        @(negedge clk);
        rst = 0;
        #1;
        check_eq("ready_before_edge", ready, 0);
        step();
        check_eq("ready_after_edge", ready, 1);

        // ADDS AL r3, result 0x80000000, CNZV=0101
        wbready = 1;
        offer(4'h4, 1, 4'hE, 4'd3, 32'h8000_0000, 4'b0101);
        step(); idle();
        check_eq("add_wbvalid", wbvalid, 1);
        check_eq("add_wbrd",    wbrd,    3);
        check_eq("add_wbdata",  wbdata,  32'h8000_0000);
        check_eq("add_nzcv",    nzcv,    4'b1001);
        check_eq("add_pcwrite", pcwrite, 0);
        step();
        check_eq("add_drained", wbvalid, 0);

        // MOVS r0, V preserved from previous ADDS
        offer(4'hD, 1, 4'hE, 4'd0, 32'h0, 4'b1010);
        step(); idle();
        check_eq("movs_nzcv",   nzcv,    4'b0111);
        check_eq("movs_wbvalid", wbvalid, 1);
        check_eq("movs_wbrd",   wbrd,    0);
        check_eq("movs_wbdata", wbdata,  0);
        step();

        // CMP then MOVEQ back-to-back, then MOVNE dropped
        offer(4'hA, 1, 4'hE, 4'd7, 32'h1234, 4'b1010);
        step();
        check_eq("cmp_nzcv",      nzcv,    4'b0110);
        check_eq("cmp_no_enqueue", wbvalid, 0);
        offer(4'hD, 0, 4'h0, 4'd5, 32'h55, 4'b0000);
        step();
        check_eq("moveq_wbvalid", wbvalid, 1);
        check_eq("moveq_wbrd",    wbrd,    5);
        check_eq("moveq_wbdata",  wbdata,  32'h55);
        check_eq("moveq_nzcv",    nzcv,    4'b0110);
        offer(4'hD, 0, 4'h1, 4'd6, 32'h66, 4'b0000);
        step(); idle();
        check_eq("movne_dropped", wbvalid, 0);
        check_eq("movne_nzcv",    nzcv,    4'b0110);

        // Write to r15 flags a PC write
        offer(4'hD, 0, 4'hE, 4'hF, 32'h100, 4'b0000);
        step(); idle();
        check_eq("pc_pcwrite", pcwrite, 1);
        check_eq("pc_wbdata",  wbdata,  32'h100);
        step();
        check_eq("pc_drained", wbvalid, 0);

        // Backpressure: three offers, two accepted
        wbready = 0;
        offer(4'hD, 0, 4'hE, 4'd1, 32'h11, 4'b0000);
        step();
        check_eq("bp_ready_one", ready, 1);
        offer(4'hD, 0, 4'hE, 4'd2, 32'h22, 4'b0000);
        step();
        check_eq("bp_ready_full", ready, 0);
        offer(4'hD, 0, 4'hE, 4'd3, 32'h33, 4'b0000);
        step(); idle();
        check_eq("bp_ready_still", ready,  0);
        check_eq("bp_head_rd",     wbrd,   1);
        check_eq("bp_head_data",   wbdata, 32'h11);
        wbready = 1;
        #1;
        check_eq("bp_ready_full_deq", ready, 0);
        step();
        check_eq("bp_drain_rd",   wbrd,   2);
        check_eq("bp_drain_data", wbdata, 32'h22);
        step();
        check_eq("bp_empty", wbvalid, 0);

        // Reset mid-stream with a full queue
        wbready = 0;
        offer(4'hD, 1, 4'hE, 4'hA, 32'hA, 4'b0100);
        step();
        offer(4'hD, 0, 4'hE, 4'hB, 32'hB, 4'b0000);
        step(); idle();
        check_eq("mid_full_ready", ready,   0);
        check_eq("mid_full_valid", wbvalid, 1);
        check_eq("mid_nzcv",       nzcv,    4'b1000);
        check_eq("mid_head_rd",    wbrd,    4'hA);
        #2;
        rst = 1;
        #1;
        check_eq("mid_rst_wbvalid", wbvalid, 0);
        check_eq("mid_rst_ready",   ready,   0);
        check_eq("mid_rst_nzcv",    nzcv,    0);
        check_eq("mid_rst_wbrd",    wbrd,    0);
        check_eq("mid_rst_wbdata",  wbdata,  0);
        check_eq("mid_rst_d4valid", d4_wbvalid, 0);
        @(negedge clk);
        rst = 0;
        #1;
        check_eq("post_rst_ready_low", ready, 0);
        step();
        check_eq("post_rst_ready", ready, 1);
        offer(4'hD, 0, 4'hE, 4'hC, 32'hC, 4'b0000);
        step();
        check_eq("resume_rd",   wbrd,    4'hC);
        check_eq("resume_d4rd", d4_wbrd, 4'hC);
        offer(4'hD, 0, 4'hE, 4'hD, 32'hD, 4'b0000);
        step(); idle();
        check_eq("pre_flush_full",  ready,    0);
        check_eq("pre_flush_d4rdy", d4_ready, 1);

        // Flush with two queued plus same-edge SUBS (Depth 4 accepts it)
        flush = 1;
        offer(4'h2, 1, 4'hE, 4'd4, 32'h44, 4'b1101);
        step(); idle();
        flush = 0;
        check_eq("flush_d4_valid", d4_wbvalid, 0);
        check_eq("flush_d4_nzcv",  d4_nzcv,    4'b1011);
        check_eq("flush_d4_ready", d4_ready,   1);
        check_eq("flush_valid",    wbvalid,    0);
        check_eq("flush_nzcv",     nzcv,       0);
        check_eq("flush_ready",    ready,      1);
        offer(4'hD, 0, 4'hE, 4'd1, 32'h77, 4'b0000);
        step(); idle();
        check_eq("post_flush_d4rd",   d4_wbrd,   1);
        check_eq("post_flush_d4data", d4_wbdata, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_writeback.md
EXEC_WRITEBACK -- requirements
Module: exec_writeback

Interface
REQ-001 The block SHALL have parameter WordWidth, default `WordWidth (32), which sets the result and data width.
REQ-002 The block SHALL have parameter Depth, default 2, which sets the writeback queue depth; Depth SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port in_Clock, input, 1 bit: the single clock.
REQ-004 The block SHALL have port in_Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_Valid, input, 1 bit: an ALU result is presented.
REQ-006 The block SHALL have port out_Ready, output, 1 bit: the block can accept a result.
REQ-007 The block SHALL have port in_Y, input, WordWidth bits: the ALU result.
REQ-008 The block SHALL have port in_CNZV, input, 4 bits: ALU flags, with [3]=C, [2]=N, [1]=Z, [0]=V.
REQ-009 The block SHALL have port in_Opcode, input, 4 bits: the ARM data-processing opcode (AND=0 ... MVN=F).
REQ-010 The block SHALL have port in_SetFlags, input, 1 bit: the instruction S bit.
REQ-011 The block SHALL have port in_Cond, input, 4 bits: the instruction condition field.
REQ-012 The block SHALL have port in_Rd, input, 4 bits: the destination register index.
REQ-013 The block SHALL have port in_Flush, input, 1 bit: discard all queued writebacks.
REQ-014 The block SHALL have port out_WbValid, output, 1 bit: the queue head is valid.
REQ-015 The block SHALL have port in_WbReady, input, 1 bit: the register file consumes the queue head.
REQ-016 The block SHALL have port out_WbRd, output, 4 bits: the head destination index.
REQ-017 The block SHALL have port out_WbData, output, WordWidth bits: the head data.
REQ-018 The block SHALL have port out_PcWrite, output, 1 bit: the head targets register 15.
REQ-019 The block SHALL have port out_NZCV, output, 4 bits: the committed flags, with [3]=N, [2]=Z, [1]=C, [0]=V.

Function
REQ-020 An accept SHALL occur on a rising edge where in_Valid and out_Ready are both 1.
REQ-021 out_Ready SHALL equal (queue count < Depth) and SHALL depend on registered state only; when the queue is full, out_Ready SHALL be 0 even if the head dequeues in the same cycle.
REQ-022 On accept, the condition SHALL be evaluated against the current out_NZCV.
REQ-023 Condition codes SHALL evaluate as: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV (F) 0.
REQ-024 A condition fail SHALL produce no enqueue and no flag update.
REQ-025 On condition pass, flags SHALL update when in_SetFlags is 1 or the opcode is 8..B (TST/TEQ/CMP/CMN).
REQ-026 For arithmetic opcodes (2..7, A, B), the flag update SHALL set all four flags from in_CNZV.
REQ-027 For logical opcodes (0, 1, 8, 9, C..F), the flag update SHALL set N, Z and C from in_CNZV and SHALL preserve V.
REQ-028 The flag update SHALL be visible on out_NZCV from the cycle after the accept, so back-to-back accepts see the prior instruction's flags.
REQ-029 On condition pass with opcode not in 8..B, {in_Rd, in_Y, in_Rd==15} SHALL be enqueued.
REQ-030 Opcodes 8..B SHALL never enqueue.
REQ-031 Latency SHALL be 1: an entry accepted at edge N appears on out_WbValid after edge N when the queue was empty; the queue has no combinational bypass.
REQ-032 A dequeue SHALL occur on an edge where out_WbValid and in_WbReady are both 1.
REQ-033 out_WbRd, out_WbData and out_PcWrite SHALL hold stable while out_WbValid=1 and in_WbReady=0.
REQ-034 Read and write pointers SHALL be log2(Depth) bits and wrap modulo Depth.
REQ-035 The count SHALL be unchanged on a simultaneous enqueue and dequeue.
REQ-036 A dequeue on an empty queue SHALL be ignored.
REQ-037 in_Flush=1 at an edge SHALL empty the queue (pointers and count to 0) and SHALL drop any same-edge enqueue and dequeue.
REQ-038 A flag update on a same-edge accept SHALL still occur during in_Flush, and out_NZCV SHALL otherwise be unaffected by in_Flush.

Reset
REQ-039 While in_Reset=1, asynchronously, the queue SHALL be empty with pointers and count at 0.
REQ-040 While in_Reset=1, out_WbValid SHALL be 0 and out_Ready SHALL be 0.
REQ-041 While in_Reset=1, out_NZCV SHALL be 4'b0000, and out_WbRd, out_WbData and out_PcWrite SHALL be 0.
REQ-042 out_Ready SHALL rise on the first edge after in_Reset deasserts.
REQ-043 Reset asserted mid-operation SHALL discard all queued entries without any dequeue handshake.

Verification
REQ-044 The bench SHALL check: ADD, S=1, cond AL, Rd=3, Y=0x80000000, CNZV=4'b0101, in_WbReady=1 -> the next cycle shows out_WbValid=1, out_WbRd=3, out_WbData=0x80000000 and out_NZCV=4'b1001.
REQ-045 The bench SHALL check: with V=1 committed, MOV S=1, Y=0, CNZV=4'b1010 -> out_NZCV=4'b0111 (V preserved), with Rd written to 0.
REQ-046 The bench SHALL check: CMP with CNZV=4'b1010, followed back-to-back by MOVEQ Rd=5 -> out_NZCV=4'b0110, CMP is not enqueued, and MOVEQ is enqueued; the bench SHALL then check that MOVNE issued next is dropped.
REQ-047 The bench SHALL check: in_WbReady=0 with 3 passing accepts offered (Depth=2) -> 2 entries are accepted, out_Ready=0, and the head is stable; in_WbReady=1 for 2 cycles then drains them in order.
REQ-048 The bench SHALL check: in_Flush asserted with 2 entries queued plus a same-edge SUB S=1 accept -> the queue is empty next cycle and out_NZCV takes the SUB flags.
REQ-049 The bench SHALL check: in_Reset pulsed mid-stream with a full queue -> out_WbValid=0 and out_NZCV=0 immediately; accepts resume after deassert.
